// File: rtl/dataset_load_ctrl_if.sv
// Bundle of dataset RAM sequencer signals: start/config, serial loader, RAM port and compute access.
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface dataset_load_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 256
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] num_dp;
  logic [3:0]            feat;
  logic                  ldr_rst;
  logic                  ldr_row_vld;
  logic [DATA_WIDTH-1:0] ldr_data;
  logic                  ldr_done;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  cmp_req;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic                  cmp_gnt;
  logic                  load_done;
  logic                  err;

  modport slave (
    input  start, num_dp, feat, ldr_row_vld, ldr_data, ldr_done, cmp_req, cmp_addr,
    output ldr_rst, ram_we, ram_oe, ram_addr, ram_wdata, cmp_gnt, load_done, err
  );

  modport master (
    output start, num_dp, feat, ldr_row_vld, ldr_data, ldr_done, cmp_req, cmp_addr,
    input  ldr_rst, ram_we, ram_oe, ram_addr, ram_wdata, cmp_gnt, load_done, err
  );
endinterface

// File: rtl/dataset_load_ctrl.sv
// Dataset RAM sequencer: writes loader rows to consecutive addresses, then lends the RAM port
// to the compute engine. Optional loader stall timeout enabled by macro DLC_TIMEOUT_EN.
module dataset_load_ctrl #(
  parameter int ADDR_WIDTH     = 12,
  parameter int MAX_FEATURES   = 15,
  parameter int LENGTH         = 16,
  parameter int DATA_WIDTH     = LENGTH * (MAX_FEATURES + 1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                CLK,
  input logic                RST_N,
  dataset_load_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, READY, SERVE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_num_dp;
  logic [3:0]            r_feat;
  logic [ADDR_WIDTH:0]   r_row_cnt;
  logic                  r_ldr_rst;
  logic                  r_ram_we;
  logic                  r_ram_oe;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic                  r_cmp_gnt;
  logic                  r_load_done;
  logic                  r_err;
  logic                  w_last_row;
  logic                  w_start_load;
  logic                  w_timeout;

  if (TIMEOUT_CYCLES < 2 || MAX_FEATURES > 15) begin : g_bad_params
    $error("dataset_load_ctrl: TIMEOUT_CYCLES must be >= 2 and MAX_FEATURES <= 15");
  end

  // Features above the active index are kept; everything below them is zeroed.
  function automatic logic [DATA_WIDTH-1:0] mask_row(input logic [DATA_WIDTH-1:0] data,
                                                     input logic [3:0]            feat);
    logic [DATA_WIDTH-1:0] low;
    low = {DATA_WIDTH{1'b1}} >> (LENGTH * (int'(feat) + 1));
    return data & ~low;
  endfunction

  assign w_last_row   = (r_row_cnt == {1'b0, r_num_dp});
  assign w_start_load = bus.start && (r_state == IDLE || r_state == READY);

`ifdef DLC_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [STALL_W-1:0] r_stall;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall <= '0;
    end else if (r_state != LOAD || bus.ldr_row_vld) begin
      r_stall <= '0;
    end else if (!w_timeout) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign w_timeout = (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_num_dp    <= '0;
      r_feat      <= '0;
      r_row_cnt   <= '0;
      r_ldr_rst   <= 1'b1;
      r_ram_we    <= 1'b0;
      r_ram_oe    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cmp_gnt   <= 1'b0;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      if (w_start_load) begin
        r_state     <= LOAD;
        r_num_dp    <= bus.num_dp;
        r_feat      <= bus.feat;
        r_row_cnt   <= '0;
        r_ldr_rst   <= 1'b0;
        r_ram_oe    <= 1'b0;
        r_cmp_gnt   <= 1'b0;
        r_load_done <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: ;
          LOAD: begin
            if (bus.ldr_row_vld) begin
              r_ram_we    <= 1'b1;
              r_ram_addr  <= r_row_cnt[ADDR_WIDTH-1:0];
              r_ram_wdata <= mask_row(bus.ldr_data, r_feat);
              r_row_cnt   <= r_row_cnt + 1'b1;
              if (w_last_row) begin
                r_state     <= READY;
                r_load_done <= 1'b1;
                r_ldr_rst   <= 1'b1;
              end
            end else if (bus.ldr_done || w_timeout) begin
              // Loader gave up early or stalled: abort and hold it in reset.
              r_err     <= 1'b1;
              r_state   <= IDLE;
              r_ldr_rst <= 1'b1;
            end
          end
          READY: begin
            r_ram_oe <= 1'b0;
            if (bus.ldr_row_vld) r_err <= 1'b1;
            if (bus.cmp_req) begin
              r_state    <= SERVE;
              r_cmp_gnt  <= 1'b1;
              r_ram_oe   <= 1'b1;
              r_ram_addr <= bus.cmp_addr;
            end
          end
          SERVE: begin
            if (bus.ldr_row_vld) r_err <= 1'b1;
            if (bus.cmp_req) begin
              r_ram_oe   <= 1'b1;
              r_ram_addr <= bus.cmp_addr;
            end else begin
              r_state   <= READY;
              r_cmp_gnt <= 1'b0;
              r_ram_oe  <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ldr_rst   = r_ldr_rst;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_oe    = r_ram_oe;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.cmp_gnt   = r_cmp_gnt;
  assign bus.load_done = r_load_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_dataset_load_ctrl.sv
// Directed bench for dataset_load_ctrl: reset, row load, feature masking, compute serve,
// error paths and loader stall behaviour (timeout variant when DLC_TIMEOUT_EN is defined).
module tb_dataset_load_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  dataset_load_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(256)) bus ();

  dataset_load_ctrl #(
    .ADDR_WIDTH(12), .MAX_FEATURES(15), .LENGTH(16), .DATA_WIDTH(256), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input logic [11:0] nd, input logic [3:0] f);
    bus.start  = 1'b1;
    bus.num_dp = nd;
    bus.feat   = f;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic push_row(input logic [255:0] d);
    bus.ldr_row_vld = 1'b1;
    bus.ldr_data    = d;
    tick();
    bus.ldr_row_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks += 8;
    if (bus.ldr_rst !== 1'b1) begin n_fail++; $display("FAIL rst_ldr_rst: got %b want 1", bus.ldr_rst); end
    if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); end
    if (bus.ram_oe !== 1'b0) begin n_fail++; $display("FAIL rst_ram_oe: got %b want 0", bus.ram_oe); end
    if (bus.ram_addr !== 12'd0) begin n_fail++; $display("FAIL rst_ram_addr: got %0d want 0", bus.ram_addr); end
    if (bus.ram_wdata !== 256'd0) begin n_fail++; $display("FAIL rst_ram_wdata: got %h want 0", bus.ram_wdata); end
    if (bus.cmp_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_cmp_gnt: got %b want 0", bus.cmp_gnt); end
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL rst_load_done: got %b want 0", bus.load_done); end
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    logic [255:0] d;
    begin_load(12'd3, 4'd15);
    n_checks += 2;
    if (bus.ldr_rst !== 1'b0) begin n_fail++; $display("FAIL load_ldr_release: got %b want 0", bus.ldr_rst); end
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL load_done_early: got %b want 0", bus.load_done); end
    for (int i = 0; i < 4; i++) begin
      d = {16{16'hA500 + 16'(i)}};
      push_row(d);
      n_checks += 4;
      if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL load_we[%0d]: got %b want 1", i, bus.ram_we); end
      if (bus.ram_addr !== 12'(i)) begin n_fail++; $display("FAIL load_addr[%0d]: got %0d want %0d", i, bus.ram_addr, i); end
      if (bus.ram_wdata !== d) begin n_fail++; $display("FAIL load_data[%0d]: got %h want %h", i, bus.ram_wdata, d); end
      if (bus.load_done !== (i == 3)) begin n_fail++; $display("FAIL load_done[%0d]: got %b want %b", i, bus.load_done, (i == 3)); end
      tick();
      n_checks++;
      if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL load_we_pulse[%0d]: got %b want 0", i, bus.ram_we); end
    end
    n_checks += 2;
    if (bus.ldr_rst !== 1'b1) begin n_fail++; $display("FAIL load_ldr_rst_end: got %b want 1", bus.ldr_rst); end
    if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL load_done_hold: got %b want 1", bus.load_done); end
  endtask

  task automatic test_mask();
    logic [255:0] exp;
    exp = {{32{1'b1}}, {224{1'b0}}};
    begin_load(12'd0, 4'd1);
    n_checks += 2;
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL mask_restart_done: got %b want 0", bus.load_done); end
    if (bus.ldr_rst !== 1'b0) begin n_fail++; $display("FAIL mask_restart_ldr: got %b want 0", bus.ldr_rst); end
    push_row({256{1'b1}});
    n_checks += 3;
    if (bus.ram_wdata !== exp) begin n_fail++; $display("FAIL mask_data: got %h want %h", bus.ram_wdata, exp); end
    if (bus.ram_addr !== 12'd0) begin n_fail++; $display("FAIL mask_addr: got %0d want 0", bus.ram_addr); end
    if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL mask_done: got %b want 1", bus.load_done); end
    tick();
  endtask

  task automatic test_serve();
    bus.cmp_req  = 1'b1;
    bus.cmp_addr = 12'd2;
    tick();
    n_checks += 4;
    if (bus.cmp_gnt !== 1'b1) begin n_fail++; $display("FAIL serve_gnt: got %b want 1", bus.cmp_gnt); end
    if (bus.ram_oe !== 1'b1) begin n_fail++; $display("FAIL serve_oe: got %b want 1", bus.ram_oe); end
    if (bus.ram_addr !== 12'd2) begin n_fail++; $display("FAIL serve_addr: got %0d want 2", bus.ram_addr); end
    if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL serve_we: got %b want 0", bus.ram_we); end
    bus.cmp_addr = 12'd5;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    n_checks += 3;
    if (bus.ram_addr !== 12'd5) begin n_fail++; $display("FAIL serve_addr_track: got %0d want 5", bus.ram_addr); end
    if (bus.cmp_gnt !== 1'b1) begin n_fail++; $display("FAIL serve_start_ignored_gnt: got %b want 1", bus.cmp_gnt); end
    if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL serve_start_ignored_done: got %b want 1", bus.load_done); end
    bus.cmp_req = 1'b0;
    tick();
    n_checks += 2;
    if (bus.cmp_gnt !== 1'b0) begin n_fail++; $display("FAIL serve_gnt_drop: got %b want 0", bus.cmp_gnt); end
    if (bus.ram_oe !== 1'b0) begin n_fail++; $display("FAIL serve_oe_drop: got %b want 0", bus.ram_oe); end
    // start and cmp_req together in READY: the new load wins
    bus.cmp_req = 1'b1;
    begin_load(12'd3, 4'd15);
    bus.cmp_req = 1'b0;
    n_checks += 3;
    if (bus.cmp_gnt !== 1'b0) begin n_fail++; $display("FAIL race_gnt: got %b want 0", bus.cmp_gnt); end
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL race_done: got %b want 0", bus.load_done); end
    if (bus.ldr_rst !== 1'b0) begin n_fail++; $display("FAIL race_ldr_rst: got %b want 0", bus.ldr_rst); end
  endtask

  task automatic test_errors();
    push_row({16{16'h1111}});
    push_row({16{16'h2222}});
    n_checks++;
    if (bus.ram_addr !== 12'd1) begin n_fail++; $display("FAIL err_row2_addr: got %0d want 1", bus.ram_addr); end
    bus.ldr_done = 1'b1;
    tick();
    bus.ldr_done = 1'b0;
    n_checks += 3;
    if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_short: got %b want 1", bus.err); end
    if (bus.ldr_rst !== 1'b1) begin n_fail++; $display("FAIL err_short_ldr_rst: got %b want 1", bus.ldr_rst); end
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL err_short_done: got %b want 0", bus.load_done); end
    push_row({16{16'h3333}});
    n_checks += 2;
    if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL err_idle_row_we: got %b want 0", bus.ram_we); end
    if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", bus.err); end
    begin_load(12'd0, 4'd15);
    n_checks++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_start: got %b want 0", bus.err); end
    push_row({16{16'h4444}});
    n_checks++;
    if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL err_reload_done: got %b want 1", bus.load_done); end
    tick();
    push_row({16{16'h5555}});
    n_checks += 3;
    if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_extra_row: got %b want 1", bus.err); end
    if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL err_extra_row_we: got %b want 0", bus.ram_we); end
    if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL err_extra_row_done: got %b want 1", bus.load_done); end
  endtask

  task automatic test_stall();
    begin_load(12'd0, 4'd15);
`ifdef DLC_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    n_checks++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0", bus.err); end
    tick();
    n_checks += 3;
    if (bus.err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", bus.err); end
    if (bus.ldr_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_ldr_rst: got %b want 1", bus.ldr_rst); end
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL timeout_done: got %b want 0", bus.load_done); end
    push_row({16{16'h6666}});
    n_checks++;
    if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL timeout_idle_we: got %b want 0", bus.ram_we); end
`else
    for (int i = 0; i < 40; i++) tick();
    n_checks += 3;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL stall_err: got %b want 0", bus.err); end
    if (bus.ldr_rst !== 1'b0) begin n_fail++; $display("FAIL stall_ldr_rst: got %b want 0", bus.ldr_rst); end
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL stall_done: got %b want 0", bus.load_done); end
    push_row({16{16'h6666}});
    n_checks += 2;
    if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL stall_late_we: got %b want 1", bus.ram_we); end
    if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL stall_late_done: got %b want 1", bus.load_done); end
`endif
  endtask

  task automatic test_reset_mid_load();
    begin_load(12'd3, 4'd15);
    push_row({16{16'h7777}});
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (bus.ldr_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_ldr_rst: got %b want 1", bus.ldr_rst); end
    if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b want 0", bus.ram_we); end
    if (bus.cmp_gnt !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt: got %b want 0", bus.cmp_gnt); end
    if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", bus.load_done); end
    if (bus.ram_wdata !== 256'd0) begin n_fail++; $display("FAIL midrst_wdata: got %h want 0", bus.ram_wdata); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    bus.start       = 1'b0;
    bus.num_dp      = '0;
    bus.feat        = '0;
    bus.ldr_row_vld = 1'b0;
    bus.ldr_data    = '0;
    bus.ldr_done    = 1'b0;
    bus.cmp_req     = 1'b0;
    bus.cmp_addr    = '0;
    test_reset();
    test_load();
    test_mask();
    test_serve();
    test_errors();
    test_stall();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
